iram_arbiter: RTL and testbench
===============================

IRAM_ARBITER -- requirements
Module: iram_arbiter

Interface
REQ-001 Parameter RAM_START, 64'h0002_0000, base byte address of the IRAM window.
REQ-002 Parameter RAM_SIZE, 1072, IRAM size in bytes; last legal address = RAM_START+RAM_SIZE-8.
REQ-003 Parameter ALIGN_CHECK, 1, when 1 an address with addr[2:0]!=0 is an error.
REQ-004 CLK  input  1  clock, all state on rising edge.
REQ-005 HRESET  input  1  reset, asynchronous, active-low.
REQ-006 if_req, if_addr  input  1, 64  instruction-fetch request (read-only) and byte address.
REQ-007 if_ack, if_err, if_rdata  output  1, 1, 64  one-cycle completion pulse, error flag, read data.
REQ-008 d_req, d_we, d_addr, d_wdata  input  1, 1, 64, 64  data-port request, write enable, address, write data.
REQ-009 d_ack, d_err, d_rdata  output  1, 1, 64  one-cycle completion pulse, error flag, read data.
REQ-010 HADDR, HWRITE, HWDATA  output  64, 1, 64  IRAM bus (IRAM writes on the clock edge, reads combinationally).
REQ-011 HRDATA  input  64  IRAM read data (high-Z when HADDR out of window).

Function
REQ-012 FSM states IDLE, ACCESS, DONE; IDLE -> ACCESS when any req sampled high; ACCESS -> DONE unconditionally; DONE -> IDLE unconditionally.
REQ-013 In IDLE, grantee chosen and its addr/we/wdata latched; if port always has we=0.
REQ-014 Simultaneous requests: grant the port not granted last (round-robin, 1-bit last_grant); single request granted immediately.
REQ-015 During ACCESS: HADDR=latched addr, HWDATA=latched wdata, HWRITE=latched we AND NOT error.
REQ-016 Outside ACCESS: HADDR=0, HWRITE=0, HWDATA=0 (no IRAM write ever outside ACCESS).
REQ-017 Error = latched addr < RAM_START, or > RAM_START+RAM_SIZE-8, or (ALIGN_CHECK and addr[2:0]!=0); comparisons 64-bit unsigned, no wrap.
REQ-018 At end of ACCESS, grantee rdata register loads HRDATA (reads, no error), else 0; err register loads error flag.
REQ-019 ack high for exactly the DONE cycle, only for the grantee; rdata/err valid in that cycle and held until next ack to that port.
REQ-020 Latency: req high in IDLE at cycle N -> ack in cycle N+2; one transaction per 3 cycles max.
REQ-021 Requester holds req/addr/data stable until ack; req sampled in IDLE after DONE belongs to a new transaction.
REQ-022 A req deasserted before grant is ignored; losing port stays pending and wins the next IDLE.

Reset
REQ-023 HRESET low: state=IDLE, last_grant=data port (if port wins first contention), all latches 0.
REQ-024 HRESET low: if_ack, d_ack, if_err, d_err=0, if_rdata, d_rdata=0, HADDR, HWDATA=0, HWRITE=0.
REQ-025 Reset mid-ACCESS or mid-DONE aborts the transaction: no ack, no further write.

Structure
REQ-026 Package iram_pkg holds RAM_START, RAM_SIZE defaults and the FSM state encoding.
REQ-027 Sub-module rr_arb2 (two-request round-robin, registered last_grant, grant-enable input) is instantiated once.

Verification
REQ-028 d write addr 0x2_0000 data 0x1122334455667788 -> HWRITE=1 one cycle, d_ack at +2, d_err=0; if read same addr -> if_rdata=0x1122334455667788.
REQ-029 if_req and d_req both high after reset -> if granted first, d acked 3 cycles later; repeat both -> alternates.
REQ-030 d write addr 0x1FFF8 and 0x2_0430 -> d_err=1, HWRITE never 1, d_rdata=0.
REQ-031 d read addr 0x2_0003 with ALIGN_CHECK=1 -> d_err=1; with ALIGN_CHECK=0 -> d_err=0, data returned.
REQ-032 HRESET low during ACCESS of a write -> no ack, FSM IDLE, all outputs 0 after release.

Source files
------------

// File: rtl/iram_pkg.sv
// Shared IRAM window defaults, arbiter FSM encoding and the address fault check.
package iram_pkg;

  localparam logic [63:0] RAM_START_DEF = 64'h0000_0000_0002_0000;
  localparam logic [63:0] RAM_SIZE_DEF  = 64'd1072;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_D  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // Unsigned 64-bit compares; start+size-8 is the highest legal doubleword.
  function automatic logic addr_fault(input logic [63:0] addr,
                                      input logic [63:0] start,
                                      input logic [63:0] size,
                                      input logic        align_chk);
    logic [63:0] last;
    last = start + size - 64'd8;
    return (addr < start) || (addr > last) || (align_chk && (addr[2:0] != 3'b000));
  endfunction

endpackage

// File: rtl/iram_arbiter_rr_arb2.sv
// Two-request round-robin arbiter; combinational grant, registered last grant.
// last_grant only advances when gnt_en is high and a request is present.
module rr_arb2
  import iram_pkg::*;
(
  input  logic       CLK,
  input  logic       HRESET,
  input  logic [1:0] req,
  input  logic       gnt_en,
  output logic       gnt_vld,
  output logic       gnt_id
);

  logic last_grant_q;
  logic last_grant_d;

  always_comb begin
    gnt_vld = |req;
    gnt_id  = PORT_IF;
    if (req[0] && req[1]) begin
      gnt_id = ~last_grant_q;
    end else if (req[1]) begin
      gnt_id = PORT_D;
    end
    last_grant_d = last_grant_q;
    if (gnt_en && gnt_vld) begin
      last_grant_d = gnt_id;
    end
  end

  // Reset to the data port so instruction fetch wins the first contention.
  always_ff @(posedge CLK or negedge HRESET) begin
    if (!HRESET) begin
      last_grant_q <= PORT_D;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/iram_arbiter.sv
// Shares one IRAM between the fetch and data ports; IDLE/ACCESS/DONE, ack two cycles
// after grant, one transaction per three cycles, losing port waits in place.
module iram_arbiter
  import iram_pkg::*;
#(
  parameter logic [63:0] RAM_START   = RAM_START_DEF,
  parameter logic [63:0] RAM_SIZE    = RAM_SIZE_DEF,
  parameter bit          ALIGN_CHECK = 1'b1
) (
  input  logic        CLK,
  input  logic        HRESET,
  input  logic        if_req,
  input  logic [63:0] if_addr,
  output logic        if_ack,
  output logic        if_err,
  output logic [63:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [63:0] d_addr,
  input  logic [63:0] d_wdata,
  output logic        d_ack,
  output logic        d_err,
  output logic [63:0] d_rdata,
  output logic [63:0] HADDR,
  output logic        HWRITE,
  output logic [63:0] HWDATA,
  input  logic [63:0] HRDATA
);

  state_e      state_q, state_d;
  logic        gnt_id_q, gnt_id_d;
  logic        we_q, we_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] if_rdata_q, if_rdata_d;
  logic [63:0] d_rdata_q, d_rdata_d;
  logic        if_err_q, if_err_d;
  logic        d_err_q, d_err_d;

  logic        arb_vld;
  logic        arb_id;
  logic        acc_err;
  logic        in_access;
  logic [63:0] acc_rdata;

  rr_arb2 u_rr_arb2 (
    .CLK     (CLK),
    .HRESET  (HRESET),
    .req     ({d_req, if_req}),
    .gnt_en  (state_q == ST_IDLE),
    .gnt_vld (arb_vld),
    .gnt_id  (arb_id)
  );

  assign in_access = (state_q == ST_ACCESS);
  assign acc_err   = addr_fault(addr_q, RAM_START, RAM_SIZE, ALIGN_CHECK);
  assign acc_rdata = (we_q || acc_err) ? 64'd0 : HRDATA;

  always_comb begin
    state_d    = state_q;
    gnt_id_d   = gnt_id_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_err_d   = if_err_q;
    d_err_d    = d_err_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_vld) begin
          state_d  = ST_ACCESS;
          gnt_id_d = arb_id;
          addr_d   = (arb_id == PORT_D) ? d_addr : if_addr;
          we_d     = (arb_id == PORT_D) ? d_we : 1'b0;
          wdata_d  = (arb_id == PORT_D) ? d_wdata : 64'd0;
        end
      end
      ST_ACCESS: begin
        state_d = ST_DONE;
        if (gnt_id_q == PORT_D) begin
          d_rdata_d = acc_rdata;
          d_err_d   = acc_err;
        end else begin
          if_rdata_d = acc_rdata;
          if_err_d   = acc_err;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge HRESET) begin
    if (!HRESET) begin
      state_q    <= ST_IDLE;
      gnt_id_q   <= PORT_IF;
      we_q       <= 1'b0;
      addr_q     <= 64'd0;
      wdata_q    <= 64'd0;
      if_rdata_q <= 64'd0;
      d_rdata_q  <= 64'd0;
      if_err_q   <= 1'b0;
      d_err_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_id_q   <= gnt_id_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      if_err_q   <= if_err_d;
      d_err_q    <= d_err_d;
    end
  end

  // The bus is only driven in ACCESS, so a faulted write never reaches the RAM.
  assign HADDR    = in_access ? addr_q : 64'd0;
  assign HWDATA   = in_access ? wdata_q : 64'd0;
  assign HWRITE   = in_access && we_q && !acc_err;

  assign if_ack   = (state_q == ST_DONE) && (gnt_id_q == PORT_IF);
  assign d_ack    = (state_q == ST_DONE) && (gnt_id_q == PORT_D);
  assign if_err   = if_err_q;
  assign d_err    = d_err_q;
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_iram_arbiter.sv
// Self-checking bench for iram_arbiter: behavioural IRAM, vector table, scoreboard queue
// and hand sequences for contention, reset abort and the no-alignment-check variant.
module tb_iram_arbiter;

  localparam logic [63:0] START = 64'h0000_0000_0002_0000;
  localparam logic [63:0] LAST  = 64'h0000_0000_0002_0428;

  logic        CLK = 1'b0;
  logic        HRESET = 1'b0;

  logic        if_req = 1'b0;
  logic [63:0] if_addr = '0;
  logic        if_ack, if_err;
  logic [63:0] if_rdata;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [63:0] d_addr = '0, d_wdata = '0;
  logic        d_ack, d_err;
  logic [63:0] d_rdata;
  logic [63:0] HADDR, HWDATA, HRDATA;
  logic        HWRITE;

  logic        if_req2 = 1'b0;
  logic [63:0] if_addr2 = '0;
  logic        if_ack2, if_err2;
  logic [63:0] if_rdata2;
  logic        d_req2 = 1'b0, d_we2 = 1'b0;
  logic [63:0] d_addr2 = '0, d_wdata2 = '0;
  logic        d_ack2, d_err2;
  logic [63:0] d_rdata2;
  logic [63:0] HADDR2, HWDATA2, HRDATA2;
  logic        HWRITE2;

  always #5 CLK = ~CLK;

  iram_arbiter dut (
    .CLK(CLK), .HRESET(HRESET),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_err(if_err), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
    .HADDR(HADDR), .HWRITE(HWRITE), .HWDATA(HWDATA), .HRDATA(HRDATA)
  );

  iram_arbiter #(.ALIGN_CHECK(1'b0)) dut_na (
    .CLK(CLK), .HRESET(HRESET),
    .if_req(if_req2), .if_addr(if_addr2), .if_ack(if_ack2), .if_err(if_err2), .if_rdata(if_rdata2),
    .d_req(d_req2), .d_we(d_we2), .d_addr(d_addr2), .d_wdata(d_wdata2),
    .d_ack(d_ack2), .d_err(d_err2), .d_rdata(d_rdata2),
    .HADDR(HADDR2), .HWRITE(HWRITE2), .HWDATA(HWDATA2), .HRDATA(HRDATA2)
  );

  // Behavioural IRAM per instance: clocked write, combinational read, Z outside window.
  logic [63:0] mem  [0:133];
  logic [63:0] mem2 [0:133];
  logic [63:0] moff, moff2;
  logic        minwin, minwin2;
  assign moff    = HADDR - START;
  assign minwin  = (HADDR >= START) && (HADDR <= LAST);
  assign HRDATA  = minwin ? mem[moff[10:3]] : {64{1'bz}};
  assign moff2   = HADDR2 - START;
  assign minwin2 = (HADDR2 >= START) && (HADDR2 <= LAST);
  assign HRDATA2 = minwin2 ? mem2[moff2[10:3]] : {64{1'bz}};
  always @(posedge CLK) if (HWRITE && minwin) mem[moff[10:3]] <= HWDATA;
  always @(posedge CLK) if (HWRITE2 && minwin2) mem2[moff2[10:3]] <= HWDATA2;

  typedef struct packed {
    logic        port;
    logic        err;
    logic [63:0] rdata;
  } exp_t;

  typedef struct {
    logic        port;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        err;
    logic [63:0] rdata;
    int          hw;
  } vec_t;

  exp_t        sb [$];
  vec_t        vt [18];
  logic [63:0] last_rd [0:1];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: no ack within cycle budget, expected ack", name);
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_flags"}, 64'({if_ack, d_ack, if_err, d_err, HWRITE}), 64'd0);
    chk({name, "_haddr"}, HADDR, 64'd0);
    chk({name, "_hwdata"}, HWDATA, 64'd0);
    chk({name, "_if_rdata"}, if_rdata, 64'd0);
    chk({name, "_d_rdata"}, d_rdata, 64'd0);
  endtask

  task automatic txn(input logic port, input logic we, input logic [63:0] addr,
                     input logic [63:0] wdata, input logic exp_err,
                     input logic [63:0] exp_rd, input int exp_hw);
    exp_t e;
    int   cyc;
    int   hw;
    logic got;
    @(negedge CLK);
    if (port) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    e.port = port; e.err = exp_err; e.rdata = exp_rd;
    sb.push_back(e);
    cyc = 0; hw = 0; got = 1'b0;
    while (!got && cyc < 10) begin
      @(negedge CLK);
      cyc++;
      if (HWRITE) hw++;
      if (if_ack || d_ack) got = 1'b1;
    end
    if (!got) begin
      timeout("txn_ack");
      sb.delete();
    end else begin
      e = sb.pop_front();
      chk("txn_latency", 64'(cyc), 64'd2);
      chk("txn_ack_port", 64'({if_ack, d_ack}), e.port ? 64'd1 : 64'd2);
      chk("txn_err", 64'(e.port ? d_err : if_err), 64'(e.err));
      chk("txn_rdata", e.port ? d_rdata : if_rdata, e.rdata);
      chk("txn_hwrite_cycles", 64'(hw), 64'(exp_hw));
      chk("txn_other_hold", e.port ? if_rdata : d_rdata, last_rd[~e.port]);
      last_rd[e.port] = e.rdata;
    end
    if_req = 1'b0;
    d_req = 1'b0;
    d_we = 1'b0;
  endtask

  // Both ports request together; the loser must be acked three cycles after the winner.
  task automatic pair(input logic first, input logic [63:0] if_a, input logic [63:0] if_exp,
                      input logic [63:0] d_a, input logic [63:0] d_exp);
    exp_t e;
    int   cyc;
    int   nack;
    @(negedge CLK);
    if_req = 1'b1; if_addr = if_a;
    d_req = 1'b1; d_we = 1'b0; d_addr = d_a; d_wdata = '0;
    e.err = 1'b0;
    e.port = first;  e.rdata = first ? d_exp : if_exp; sb.push_back(e);
    e.port = ~first; e.rdata = first ? if_exp : d_exp; sb.push_back(e);
    cyc = 0; nack = 0;
    while (nack < 2 && cyc < 12) begin
      @(negedge CLK);
      cyc++;
      if ((if_ack || d_ack) && sb.size() > 0) begin
        e = sb.pop_front();
        chk("pair_port", 64'({if_ack, d_ack}), e.port ? 64'd1 : 64'd2);
        chk("pair_cycle", 64'(cyc), (nack == 0) ? 64'd2 : 64'd5);
        chk("pair_rdata", d_ack ? d_rdata : if_rdata, e.rdata);
        if (d_ack) d_req = 1'b0;
        if (if_ack) if_req = 1'b0;
        last_rd[e.port] = e.rdata;
        nack++;
      end
    end
    if (nack < 2) timeout("pair_ack");
    if_req = 1'b0;
    d_req = 1'b0;
    sb.delete();
  endtask

  task automatic na_txn(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                        input logic exp_err, input logic [63:0] exp_rd);
    int   cyc;
    logic got;
    @(negedge CLK);
    d_req2 = 1'b1; d_we2 = we; d_addr2 = addr; d_wdata2 = wdata;
    cyc = 0; got = 1'b0;
    while (!got && cyc < 10) begin
      @(negedge CLK);
      cyc++;
      if (d_ack2 || if_ack2) got = 1'b1;
    end
    if (!got) begin
      timeout("na_ack");
    end else begin
      chk("na_ack_port", 64'({if_ack2, d_ack2}), 64'd1);
      chk("na_err", 64'(d_err2), 64'(exp_err));
      chk("na_rdata", d_rdata2, exp_rd);
    end
    d_req2 = 1'b0;
    d_we2 = 1'b0;
  endtask

  initial begin
    int acks;
    vt[0]  = '{1'b1, 1'b1, 64'h2_0000, 64'h1122334455667788, 1'b0, 64'h0, 1};
    vt[1]  = '{1'b0, 1'b0, 64'h2_0000, 64'h0, 1'b0, 64'h1122334455667788, 0};
    vt[2]  = '{1'b1, 1'b0, 64'h2_0000, 64'h0, 1'b0, 64'h1122334455667788, 0};
    vt[3]  = '{1'b1, 1'b1, 64'h2_0428, 64'hA5A5A5A55A5A5A5A, 1'b0, 64'h0, 1};
    vt[4]  = '{1'b0, 1'b0, 64'h2_0428, 64'h0, 1'b0, 64'hA5A5A5A55A5A5A5A, 0};
    vt[5]  = '{1'b1, 1'b1, 64'h1_FFF8, 64'hDEADDEADDEADDEAD, 1'b1, 64'h0, 0};
    vt[6]  = '{1'b1, 1'b1, 64'h2_0430, 64'hBEEFBEEFBEEFBEEF, 1'b1, 64'h0, 0};
    vt[7]  = '{1'b1, 1'b0, 64'h2_0430, 64'h0, 1'b1, 64'h0, 0};
    vt[8]  = '{1'b0, 1'b0, 64'h2_0430, 64'h0, 1'b1, 64'h0, 0};
    vt[9]  = '{1'b0, 1'b0, 64'h2_0003, 64'h0, 1'b1, 64'h0, 0};
    vt[10] = '{1'b1, 1'b0, 64'h2_0003, 64'h0, 1'b1, 64'h0, 0};
    vt[11] = '{1'b1, 1'b0, 64'h0, 64'h0, 1'b1, 64'h0, 0};
    vt[12] = '{1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 1'b1, 64'h0, 0};
    vt[13] = '{1'b1, 1'b1, 64'h2_0010, 64'h5555AAAA5555AAAA, 1'b0, 64'h0, 1};
    vt[14] = '{1'b0, 1'b0, 64'h2_0010, 64'h0, 1'b0, 64'h5555AAAA5555AAAA, 0};
    vt[15] = '{1'b1, 1'b0, 64'h2_0428, 64'h0, 1'b0, 64'hA5A5A5A55A5A5A5A, 0};
    vt[16] = '{1'b1, 1'b1, 64'h2_0008, 64'h0123456789ABCDEF, 1'b0, 64'h0, 1};
    vt[17] = '{1'b0, 1'b0, 64'h2_0008, 64'h0, 1'b0, 64'h0123456789ABCDEF, 0};
    last_rd[0] = '0;
    last_rd[1] = '0;

    repeat (2) @(negedge CLK);
    chk_idle("reset");
    HRESET = 1'b1;
    @(negedge CLK);
    chk_idle("post_reset");

    foreach (vt[i]) begin
      txn(vt[i].port, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].err, vt[i].rdata, vt[i].hw);
    end

    // Reset while a write is on the bus: nothing written, no ack, outputs cleared.
    @(negedge CLK);
    d_req = 1'b1; d_we = 1'b1; d_addr = 64'h2_0010; d_wdata = 64'hCAFECAFECAFECAFE;
    @(negedge CLK);
    chk("abort_hwrite_in_access", 64'(HWRITE), 64'd1);
    HRESET = 1'b0;
    #1;
    chk_idle("abort_in_reset");
    d_req = 1'b0; d_we = 1'b0;
    last_rd[0] = '0;
    last_rd[1] = '0;
    repeat (2) @(negedge CLK);
    HRESET = 1'b1;
    acks = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      if (if_ack || d_ack) acks++;
    end
    chk("abort_no_ack", 64'(acks), 64'd0);
    chk_idle("abort_released");

    pair(1'b0, 64'h2_0000, 64'h1122334455667788, 64'h2_0428, 64'hA5A5A5A55A5A5A5A);
    pair(1'b0, 64'h2_0008, 64'h0123456789ABCDEF, 64'h2_0000, 64'h1122334455667788);
    txn(1'b0, 1'b0, 64'h2_0010, 64'h0, 1'b0, 64'h5555AAAA5555AAAA, 0);
    pair(1'b1, 64'h2_0428, 64'hA5A5A5A55A5A5A5A, 64'h2_0008, 64'h0123456789ABCDEF);

    na_txn(1'b1, 64'h2_0000, 64'h0BADF00D12345678, 1'b0, 64'h0);
    na_txn(1'b0, 64'h2_0003, 64'h0, 1'b0, 64'h0BADF00D12345678);
    na_txn(1'b0, 64'h2_0430, 64'h0, 1'b1, 64'h0);
    chk("na_if_idle", 64'({if_err2, if_rdata2 != 64'd0}), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
